// File: rtl/mem_pkg.sv
// mem_pkg: shared types and widths for the two-master memory arbiter.
//   ADDR_W / DATA_W / BSEL_W : word-address, data and byte-select widths
//   state_t                  : arbiter grant state
//   port_req_t               : one master's request bundle (everything it drives)
package mem_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int BSEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              access;
    logic              wr_en;
    logic [BSEL_W-1:0] bytesel;
  } port_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_bus_if: one memory bus connection (address is a word address, addr[19:1]).
//   addr, data_out, access, wr_en, bytesel : driven by the master
//   data_in, ack                           : driven by the slave
//   modport master : the side issuing requests
//   modport slave  : the side answering requests
interface mem_bus_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              access;
  logic              ack;
  logic              wr_en;
  logic [BSEL_W-1:0] bytesel;

  modport master (
    output addr, data_out, access, wr_en, bytesel,
    input  data_in, ack
  );

  modport slave (
    input  addr, data_out, access, wr_en, bytesel,
    output data_in, ack
  );

endinterface

// File: rtl/mem_arbiter_mux.sv
// mem_port_mux: combinational 2:1 selector of a full request bundle.
//   sel   : current grant state; IDLE selects nothing
//   req_a : request bundle from master A
//   req_b : request bundle from master B
//   req_q : bundle forwarded downstream, all-zero when nothing is granted
module mem_port_mux
  import mem_pkg::*;
(
  input  state_t    sel,
  input  port_req_t req_a,
  input  port_req_t req_b,
  output port_req_t req_q
);

  // Idle bus is driven to all zeros so the memory never sees a stale request.
  always_comb begin
    req_q = '0;
    case (sel)
      GRANT_A: req_q = req_a;
      GRANT_B: req_q = req_b;
      default: req_q = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a data
// load/store master (A) and an instruction prefetch master (B).
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   a_m    : slave side facing master A
//   b_m    : slave side facing master B
//   q_m    : master side facing the shared memory
//   q_busy : high while a grant is held
module mem_arbiter
  import mem_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  mem_bus_if.slave  a_m,
  mem_bus_if.slave  b_m,
  mem_bus_if.master q_m,
  output logic      q_busy
);

  state_t    state_q, state_d;
  logic      last_served_q, last_served_d;
  port_req_t req_a, req_b, req_q;

  assign req_a = '{addr: a_m.addr, data_out: a_m.data_out, access: a_m.access,
                   wr_en: a_m.wr_en, bytesel: a_m.bytesel};
  assign req_b = '{addr: b_m.addr, data_out: b_m.data_out, access: b_m.access,
                   wr_en: b_m.wr_en, bytesel: b_m.bytesel};

  // State register. last_served resets to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

  // Next-state logic. Every grant returns to IDLE when it ends, so a master
  // re-requesting straight after its ack competes again and loses a tie.
  // The ack is checked before access because a master may drop access in
  // its ack cycle.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (a_m.access && b_m.access)
          state_d = last_served_q ? GRANT_A : GRANT_B;
        else if (a_m.access)
          state_d = GRANT_A;
        else if (b_m.access)
          state_d = GRANT_B;
      end
      GRANT_A: begin
        if (q_m.ack) begin
          state_d       = IDLE;
          last_served_d = 1'b0;
        end else if (!a_m.access) begin
          state_d = IDLE;
        end
      end
      GRANT_B: begin
        if (q_m.ack) begin
          state_d       = IDLE;
          last_served_d = 1'b1;
        end else if (!b_m.access) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_port_mux u_mux (
    .sel   (state_q),
    .req_a (req_a),
    .req_b (req_b),
    .req_q (req_q)
  );

  assign q_m.addr     = req_q.addr;
  assign q_m.data_out = req_q.data_out;
  assign q_m.access   = req_q.access;
  assign q_m.wr_en    = req_q.wr_en;
  assign q_m.bytesel  = req_q.bytesel;

  // An ack arriving while idle belongs to nobody and is dropped.
  assign a_m.ack     = (state_q == GRANT_A) && q_m.ack;
  assign b_m.ack     = (state_q == GRANT_B) && q_m.ack;
  assign a_m.data_in = q_m.data_in;
  assign b_m.data_in = q_m.data_in;

  assign q_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk;
  logic reset;
  logic q_busy;
  int   checks;
  int   errors;

  mem_bus_if a_m ();
  mem_bus_if b_m ();
  mem_bus_if q_m ();

  mem_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .a_m    (a_m.slave),
    .b_m    (b_m.slave),
    .q_m    (q_m.master),
    .q_busy (q_busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, away from the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one master's request fields; port_is_b selects B, otherwise A.
  task automatic applyStimulus(input logic port_is_b, input logic access,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data,
                               input logic wr_en, input logic [BSEL_W-1:0] bytesel);
    if (port_is_b) begin
      b_m.access = access; b_m.addr = addr; b_m.data_out = data;
      b_m.wr_en = wr_en;   b_m.bytesel = bytesel;
    end else begin
      a_m.access = access; a_m.addr = addr; a_m.data_out = data;
      a_m.wr_en = wr_en;   a_m.bytesel = bytesel;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    q_m.ack = 1'b0;
    q_m.data_in = '0;

    // Reset held low for two cycles
    nextCycle();
    nextCycle();
    checkOutput("rst_busy",   q_busy,       0);
    checkOutput("rst_access", q_m.access,   0);
    checkOutput("rst_addr",   q_m.addr,     0);
    checkOutput("rst_a_ack",  a_m.ack,      0);
    checkOutput("rst_b_ack",  b_m.ack,      0);
    reset = 1'b1;

    // Single A access: one cycle latency, then ack routed to A only
    nextCycle();
    applyStimulus(1'b0, 1'b1, 19'h00100, 16'h0000, 1'b0, 2'b11);
    #1;
    checkOutput("t1_latency_access", q_m.access, 0);
    nextCycle();
    checkOutput("t1_access", q_m.access, 1);
    checkOutput("t1_addr",   q_m.addr,   19'h00100);
    checkOutput("t1_busy",   q_busy,     1);
    q_m.ack = 1'b1; q_m.data_in = 16'h1234; a_m.access = 1'b0;
    #1;
    checkOutput("t1_a_ack",  a_m.ack,     1);
    checkOutput("t1_b_ack",  b_m.ack,     0);
    checkOutput("t1_a_data", a_m.data_in, 16'h1234);
    nextCycle();
    q_m.ack = 1'b0;
    #1;
    checkOutput("t1_idle_busy", q_busy,  0);
    checkOutput("t1_a_ack_off", a_m.ack, 0);

    // Simultaneous request after reset: A, then B, then A again
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 19'h00200, 16'h0000, 1'b0, 2'b11);
    applyStimulus(1'b1, 1'b1, 19'h7FFF0, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    checkOutput("t2_first_addr", q_m.addr, 19'h00200);
    q_m.ack = 1'b1; a_m.access = 1'b0;
    #1;
    checkOutput("t2_first_a_ack", a_m.ack, 1);
    nextCycle();
    q_m.ack = 1'b0;
    applyStimulus(1'b0, 1'b1, 19'h00300, 16'h0000, 1'b0, 2'b11);
    #1;
    checkOutput("t2_idle_access", q_m.access, 0);
    nextCycle();
    checkOutput("t2_second_addr", q_m.addr, 19'h7FFF0);
    q_m.ack = 1'b1; b_m.access = 1'b0;
    #1;
    checkOutput("t2_second_b_ack", b_m.ack, 1);
    checkOutput("t2_second_a_ack", a_m.ack, 0);
    nextCycle();
    q_m.ack = 1'b0;
    nextCycle();
    checkOutput("t2_third_addr", q_m.addr, 19'h00300);
    q_m.ack = 1'b1; a_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;

    // Unaligned A write split in two while B waits: order A, B, A
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 19'h00400, 16'hAAAA, 1'b1, 2'b10);
    applyStimulus(1'b1, 1'b1, 19'h00500, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    checkOutput("t3_a1_addr",    q_m.addr,     19'h00400);
    checkOutput("t3_a1_data",    q_m.data_out, 16'hAAAA);
    checkOutput("t3_a1_bytesel", q_m.bytesel,  2'b10);
    checkOutput("t3_a1_wr_en",   q_m.wr_en,    1);
    q_m.ack = 1'b1; a_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;
    applyStimulus(1'b0, 1'b1, 19'h00401, 16'h5555, 1'b1, 2'b01);
    #1;
    checkOutput("t3_idle_data",    q_m.data_out, 0);
    checkOutput("t3_idle_bytesel", q_m.bytesel,  0);
    checkOutput("t3_idle_wr_en",   q_m.wr_en,    0);
    checkOutput("t3_idle_addr",    q_m.addr,     0);
    nextCycle();
    checkOutput("t3_b_addr",  q_m.addr,  19'h00500);
    checkOutput("t3_b_wr_en", q_m.wr_en, 0);
    q_m.ack = 1'b1; b_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;
    nextCycle();
    checkOutput("t3_a2_addr",    q_m.addr,     19'h00401);
    checkOutput("t3_a2_data",    q_m.data_out, 16'h5555);
    checkOutput("t3_a2_bytesel", q_m.bytesel,  2'b01);
    q_m.ack = 1'b1; a_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;

    // B read returning 16'hBEEF
    applyStimulus(1'b1, 1'b1, 19'h00600, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    q_m.ack = 1'b1; q_m.data_in = 16'hBEEF; b_m.access = 1'b0;
    #1;
    checkOutput("t4_b_data", b_m.data_in, 16'hBEEF);
    checkOutput("t4_b_ack",  b_m.ack,     1);
    checkOutput("t4_a_ack",  a_m.ack,     0);
    nextCycle();
    q_m.ack = 1'b0;
    #1;
    checkOutput("t4_b_ack_one_cycle", b_m.ack, 0);

    // Reset during GRANT_B, ack arriving as reset releases
    applyStimulus(1'b1, 1'b1, 19'h00700, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    checkOutput("t5_granted_b", q_busy, 1);
    reset = 1'b0;
    nextCycle();
    checkOutput("t5_rst_access", q_m.access, 0);
    checkOutput("t5_rst_busy",   q_busy,     0);
    reset = 1'b1; q_m.ack = 1'b1; b_m.access = 1'b0;
    #1;
    checkOutput("t5_late_b_ack", b_m.ack,    0);
    checkOutput("t5_late_a_ack", a_m.ack,    0);
    checkOutput("t5_access",     q_m.access, 0);
    nextCycle();
    q_m.ack = 1'b0;
    #1;
    checkOutput("t5_idle_after", q_busy, 0);

    // Spurious ack in IDLE, then A abandons a grant without ack
    q_m.ack = 1'b1;
    #1;
    checkOutput("t6_spurious_a_ack", a_m.ack, 0);
    checkOutput("t6_spurious_b_ack", b_m.ack, 0);
    nextCycle();
    q_m.ack = 1'b0;
    checkOutput("t6_spurious_busy", q_busy, 0);
    applyStimulus(1'b0, 1'b1, 19'h00800, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    checkOutput("t6_a_granted", q_busy, 1);
    a_m.access = 1'b0;
    #1;
    checkOutput("t6_drop_access", q_m.access, 0);
    nextCycle();
    checkOutput("t6_drop_idle", q_busy, 0);
    // last_served still B, so a tie must again go to A
    applyStimulus(1'b0, 1'b1, 19'h00900, 16'h0000, 1'b0, 2'b11);
    applyStimulus(1'b1, 1'b1, 19'h00A00, 16'h0000, 1'b0, 2'b11);
    nextCycle();
    checkOutput("t6_tie_to_a", q_m.addr, 19'h00900);
    q_m.ack = 1'b1; a_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;
    nextCycle();
    checkOutput("t6_then_b", q_m.addr, 19'h00A00);
    q_m.ack = 1'b1; b_m.access = 1'b0;
    nextCycle();
    q_m.ack = 1'b0;
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising clk only.
REQ-003 a_m_addr / a_m_data_out / a_m_data_in / a_m_access / a_m_ack / a_m_wr_en / a_m_bytesel  in/in/out/in/out/in/in  19(addr[19:1])/16/16/1/1/1/2  port A: data load/store master, upstream.
REQ-004 b_m_addr / b_m_data_out / b_m_data_in / b_m_access / b_m_ack / b_m_wr_en / b_m_bytesel  in/in/out/in/out/in/in  19/16/16/1/1/1/2  port B: instruction prefetch master, read-only use expected but not enforced.
REQ-005 q_m_addr / q_m_data_out / q_m_data_in / q_m_access / q_m_ack / q_m_wr_en / q_m_bytesel  out/out/in/out/in/out/out  19/16/16/1/1/1/2  shared downstream memory port.
REQ-006 q_busy  out  1  high while any grant is held.

Function
REQ-007 Masters SHALL hold access and all request fields stable until their ack; access may drop combinationally in the ack cycle.
REQ-008 FSM states SHALL be IDLE, GRANT_A, GRANT_B; state register plus one last_served bit (0=A, 1=B).
REQ-009 IDLE: only A requesting -> GRANT_A; only B -> GRANT_B; both -> master not equal to last_served; none -> stay IDLE.
REQ-010 Grant SHALL take effect the cycle after the request is sampled: minimum one cycle of request-to-q_m_access latency.
REQ-011 In GRANT_x, q_m_addr/data_out/wr_en/bytesel SHALL be combinationally driven from port x; q_m_access = x_m_access.
REQ-012 Not granted: q_m_access=0, q_m_wr_en=0, q_m_bytesel=2'b00, q_m_addr=0, q_m_data_out=0.
REQ-013 q_m_ack SHALL route combinationally to granted port's ack only; non-granted ack held 0.
REQ-014 q_m_data_in SHALL be broadcast to both a_m_data_in and b_m_data_in; validity defined solely by that port's ack.
REQ-015 On q_m_ack in GRANT_x, FSM SHALL return to IDLE next cycle and last_served SHALL update to x.
REQ-016 Back-to-back: master re-asserting access the cycle after its ack re-enters arbitration from IDLE; if other master pending, other master wins (round-robin).
REQ-017 Granted master dropping access without ack (protocol violation) SHALL return FSM to IDLE next cycle, last_served unchanged.
REQ-018 q_m_ack while IDLE SHALL be ignored; no port ack, no state change.
REQ-019 q_busy = (state != IDLE).
REQ-020 No request queuing beyond one outstanding transaction; a two-transfer unaligned access from A is two independent arbitrations.

Reset
REQ-021 reset low SHALL force state=IDLE, last_served=1 (A wins first tie) on next rising edge.
REQ-022 Reset mid-transfer SHALL abandon grant; all q_m_* outputs at REQ-012 values the cycle after reset sampled; late q_m_ack discarded per REQ-018.
REQ-023 All outputs SHALL be defined (no X) during and after reset.

Structure
REQ-024 State enum (IDLE, GRANT_A, GRANT_B) and port-width constants (address 19, data 16, bytesel 2) SHALL live in shared package mem_pkg.
REQ-025 Single module; one sub-module, mem_port_mux (combinational 2:1 mux of a full port bundle), is natural and permitted.

Verification
REQ-026 Reset low 2 cycles, release, A access addr 19'h00100 -> q_m_access one cycle later with q_m_addr=19'h00100; ack -> a_m_ack=1, b_m_ack=0.
REQ-027 A and B assert same cycle after reset -> A granted first; after A ack, B (addr 19'h7FFF0) granted next, then A again if re-requested.
REQ-028 A issues back-to-back unaligned write (bytesel 10 then 01) while B pending -> order A, B, A; q_m_data_out matches A data each grant.
REQ-029 B read, memory returns 16'hBEEF with ack -> b_m_data_in=16'hBEEF, b_m_ack=1 one cycle, a_m_ack=0.
REQ-030 Reset asserted during GRANT_B with ack arriving same cycle as reset release -> no port ack, q_m_access=0, state IDLE.
REQ-031 Spurious q_m_ack in IDLE and A dropping access mid-grant -> no ack forwarded, FSM IDLE next cycle, last_served unchanged.
